// File: rtl/eth_ack_tx_pkg.sv
// Shared types, constants and CRC helper for the ack frame transmitter.
// Segment lengths are in bytes; counters run 0..LEN-1 within each segment.
package eth_ack_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_FCS      = 3'd4,
    ST_IFG      = 3'd5
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned HEADER_LEN   = 14;
  localparam int unsigned PAYLOAD_LEN  = 46;
  localparam int unsigned FCS_LEN      = 4;
  localparam int unsigned IFG_LEN      = 12;

  localparam int CNT_W = 6;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [47:0] dst;
    logic [15:0] status;
  } ack_entry_t;

  // Reflected CRC-32 advanced by one byte, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic cnt_t seg_last(input state_t s);
    case (s)
      ST_PREAMBLE: return cnt_t'(PREAMBLE_LEN - 1);
      ST_HEADER:   return cnt_t'(HEADER_LEN - 1);
      ST_PAYLOAD:  return cnt_t'(PAYLOAD_LEN - 1);
      ST_FCS:      return cnt_t'(FCS_LEN - 1);
      ST_IFG:      return cnt_t'(IFG_LEN - 1);
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/eth_ack_tx_if.sv
// Ack FIFO read side plus GMII-style transmit side of the ack frame generator.
interface eth_ack_tx_if;

  logic        ack_rd_en_out;
  logic [63:0] ack_rd_d_in;
  logic        ack_rd_empty_in;
  logic        tx_en_out;
  logic [7:0]  txd_out;
  logic        busy_out;
  logic [15:0] frame_count_out;

  modport master (
    output ack_rd_en_out, tx_en_out, txd_out, busy_out, frame_count_out,
    input  ack_rd_d_in, ack_rd_empty_in
  );

  modport slave (
    input  ack_rd_en_out, tx_en_out, txd_out, busy_out, frame_count_out,
    output ack_rd_d_in, ack_rd_empty_in
  );

endinterface

// File: rtl/eth_ack_tx_crc32_d8.sv
// Byte-wide reflected CRC-32 register; one byte per enabled cycle, result next cycle.
// init has priority over en; the register is left uninverted.
module crc32_d8
  import eth_ack_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, d);
    end
  end

endmodule

// File: rtl/eth_ack_tx.sv
// Builds one 72-byte Ethernet ack frame per FIFO entry; tx starts two cycles after the read request.
// Transmission cannot be stalled; the FIFO is only read in IDLE, so entries wait there.
module eth_ack_tx
  import eth_ack_tx_pkg::*;
#(
  parameter logic [47:0] MAC  = 48'h010203040506,
  parameter logic [15:0] TYPE = 16'hffff
) (
  input  logic         clk,
  input  logic         rst,
  eth_ack_tx_if.master bus
);

  state_t      state, state_nxt;
  cnt_t        cnt;
  logic        seg_done;
  logic        rd_en;
  logic        rd_pend;
  logic        capture;
  ack_entry_t  entry_q;
  logic [15:0] seq_q;
  logic [15:0] frame_cnt_q;

  logic        tx_en;
  logic [7:0]  txd;
  logic [7:0]  pay_byte;
  logic        crc_init;
  logic        crc_en;
  logic [31:0] crc;
  logic [31:0] fcs_sh;
  logic [111:0] hdr_vec;
  logic [111:0] hdr_sh;

  assign seg_done = (cnt == seg_last(state));

  // Read accepted last cycle means the entry is on ack_rd_d_in now.
  assign capture = (state == ST_IDLE) && rd_pend;
  assign rd_en   = !rst && (state == ST_IDLE) && !rd_pend && !bus.ack_rd_empty_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (capture)  state_nxt = ST_PREAMBLE;
      ST_PREAMBLE: if (seg_done) state_nxt = ST_HEADER;
      ST_HEADER:   if (seg_done) state_nxt = ST_PAYLOAD;
      ST_PAYLOAD:  if (seg_done) state_nxt = ST_FCS;
      ST_FCS:      if (seg_done) state_nxt = ST_IFG;
      ST_IFG:      if (seg_done) state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // seg_last(ST_IDLE) is 0, so the counter parks at 0 while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (seg_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      seq_q   <= '0;
    end else if (capture) begin
      entry_q <= ack_entry_t'(bus.ack_rd_d_in);
      seq_q   <= frame_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if ((state == ST_FCS) && seg_done) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign hdr_vec = {entry_q.dst, MAC, TYPE};
  assign hdr_sh  = hdr_vec << {cnt, 3'b000};
  assign fcs_sh  = (~crc) >> {cnt[1:0], 3'b000};

  always_comb begin
    pay_byte = 8'h00;
    case (cnt)
      cnt_t'(0): pay_byte = entry_q.status[15:8];
      cnt_t'(1): pay_byte = entry_q.status[7:0];
      cnt_t'(2): pay_byte = seq_q[15:8];
      cnt_t'(3): pay_byte = seq_q[7:0];
      default:   pay_byte = 8'h00;
    endcase
  end

  always_comb begin
    tx_en    = 1'b0;
    txd      = 8'h00;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    case (state)
      ST_PREAMBLE: begin
        tx_en    = 1'b1;
        crc_init = 1'b1;
        txd      = seg_done ? SFD_BYTE : PREAMBLE_BYTE;
      end
      ST_HEADER: begin
        tx_en  = 1'b1;
        crc_en = 1'b1;
        txd    = hdr_sh[111:104];
      end
      ST_PAYLOAD: begin
        tx_en  = 1'b1;
        crc_en = 1'b1;
        txd    = pay_byte;
      end
      ST_FCS: begin
        tx_en = 1'b1;
        txd   = fcs_sh[7:0];
      end
      default: begin
        tx_en = 1'b0;
        txd   = 8'h00;
      end
    endcase
  end

  crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .d    (txd),
    .crc  (crc)
  );

  assign bus.ack_rd_en_out   = rd_en;
  assign bus.tx_en_out       = tx_en;
  assign bus.txd_out         = txd;
  assign bus.busy_out        = (state != ST_IDLE);
  assign bus.frame_count_out = frame_cnt_q;

endmodule

// File: tb/tb_eth_ack_tx.sv
// Directed bench for eth_ack_tx: a queue-backed FIFO model feeds entries, frames are checked bytewise.
module tb_eth_ack_tx;
  import eth_ack_tx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  eth_ack_tx_if bus();

  eth_ack_tx #(.MAC(48'h010203040506), .TYPE(16'hffff)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q[$];
  int          rd_evt = 0;
  bit          tog = 1'b0;
  bit          tgl = 1'b0;
  logic [7:0]  frm[72];
  logic [7:0]  exp_frm[72];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int j = 0; j < 8; j++) begin
      fb = r[0] ^ b[j];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build_exp(input logic [47:0] dst, input logic [15:0] st, input logic [15:0] seq);
    logic [111:0] h;
    logic [31:0]  c;
    for (int i = 0; i < 7; i++) exp_frm[i] = 8'h55;
    exp_frm[7] = 8'hD5;
    h = {dst, 48'h010203040506, 16'hffff};
    for (int i = 0; i < 14; i++) exp_frm[8+i] = h[111-8*i -: 8];
    exp_frm[22] = st[15:8];
    exp_frm[23] = st[7:0];
    exp_frm[24] = seq[15:8];
    exp_frm[25] = seq[7:0];
    for (int i = 26; i < 68; i++) exp_frm[i] = 8'h00;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 68; i++) c = crc_step(c, exp_frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) exp_frm[68+i] = c[8*i +: 8];
  endtask

  task automatic wait_tx(output int w);
    w = 0;
    while (!bus.tx_en_out && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("tx_en_rise", 64'(bus.tx_en_out), 64'd1);
  endtask

  task automatic rx_frame(input bit tog_during, output int w);
    int gaps;
    wait_tx(w);
    tog  = tog_during;
    gaps = 0;
    for (int i = 0; i < 72; i++) begin
      frm[i] = bus.txd_out;
      if (!bus.tx_en_out) gaps++;
      @(negedge clk);
    end
    tog = 1'b0;
    chk("tx_en_72_high", 64'(gaps), 64'd0);
    chk("tx_en_fall", 64'(bus.tx_en_out), 64'd0);
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] c;
    for (int i = 0; i < 72; i++) begin
      chk($sformatf("%s_byte%0d", tag, i + 1), 64'(frm[i]), 64'(exp_frm[i]));
    end
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 72; i++) c = crc_step(c, frm[i]);
    chk({tag, "_residue"}, 64'(c), 64'(CRC_RESIDUE));
  endtask

  // FIFO model: a read requested before a rising edge delivers data just after it.
  initial begin
    bus.ack_rd_d_in     = '0;
    bus.ack_rd_empty_in = 1'b1;
    forever begin
      bit rd;
      @(negedge clk);
      rd = bus.ack_rd_en_out && !bus.ack_rd_empty_in;
      @(posedge clk);
      #1;
      if (rd) begin
        rd_evt++;
        if (q.size() > 0) bus.ack_rd_d_in = q.pop_front();
      end
      tgl = ~tgl;
      bus.ack_rd_empty_in = (q.size() == 0) ? (tog ? tgl : 1'b1) : 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   w;
    int   ev0;
    logic saw_rd, saw_tx, saw_busy;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 64'(bus.ack_rd_en_out), 64'd0);
    chk("rst_tx_en", 64'(bus.tx_en_out), 64'd0);
    chk("rst_txd", 64'(bus.txd_out), 64'd0);
    chk("rst_busy", 64'(bus.busy_out), 64'd0);
    chk("rst_frame_count", 64'(bus.frame_count_out), 64'd0);
    rst = 1'b0;

    saw_rd = 1'b0; saw_tx = 1'b0; saw_busy = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      saw_rd   |= bus.ack_rd_en_out;
      saw_tx   |= bus.tx_en_out | (bus.txd_out != 8'h00);
      saw_busy |= bus.busy_out;
    end
    chk("idle_rd_en", 64'(saw_rd), 64'd0);
    chk("idle_tx", 64'(saw_tx), 64'd0);
    chk("idle_busy", 64'(saw_busy), 64'd0);
    chk("idle_reads", 64'(rd_evt), 64'd0);

    q.push_back({48'h0a0b0c0d0e0f, 16'h1234});
    build_exp(48'h0a0b0c0d0e0f, 16'h1234, 16'h0000);
    rx_frame(1'b0, w);
    chk("single_latency", 64'(w), 64'd3);
    check_frame("single");
    chk("single_hdr_mac_lo", 64'(frm[19]), 64'h06);
    chk("single_ifg_busy", 64'(bus.busy_out), 64'd1);
    chk("single_ifg_txd", 64'(bus.txd_out), 64'd0);
    chk("single_count", 64'(bus.frame_count_out), 64'd1);
    chk("single_reads", 64'(rd_evt), 64'd1);
    repeat (20) @(negedge clk);
    chk("single_idle_busy", 64'(bus.busy_out), 64'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("b2b_count_cleared", 64'(bus.frame_count_out), 64'd0);
    q.push_back({48'hfedcba987654, 16'hbeef});
    q.push_back({48'h112233445566, 16'h0001});
    build_exp(48'hfedcba987654, 16'hbeef, 16'h0000);
    rx_frame(1'b0, w);
    check_frame("b2b_first");
    build_exp(48'h112233445566, 16'h0001, 16'h0001);
    rx_frame(1'b0, w);
    chk("b2b_gap", 64'(w), 64'd14);
    check_frame("b2b_second");
    chk("b2b_reads", 64'(rd_evt), 64'd3);
    chk("b2b_count", 64'(bus.frame_count_out), 64'd2);

    repeat (20) @(negedge clk);
    q.push_back({48'h0000c0ffee00, 16'h5a5a});
    wait_tx(w);
    repeat (29) @(negedge clk);
    chk("mid_pre_rst_tx_en", 64'(bus.tx_en_out), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_en", 64'(bus.tx_en_out), 64'd0);
    chk("mid_rst_txd", 64'(bus.txd_out), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy_out), 64'd0);
    chk("mid_rst_rd_en", 64'(bus.ack_rd_en_out), 64'd0);
    chk("mid_rst_count", 64'(bus.frame_count_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_tx = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_tx |= bus.tx_en_out | bus.busy_out;
    end
    chk("mid_no_resume", 64'(saw_tx), 64'd0);
    q.push_back({48'h665544332211, 16'h0f0f});
    build_exp(48'h665544332211, 16'h0f0f, 16'h0000);
    rx_frame(1'b0, w);
    check_frame("post_rst");
    chk("post_rst_count", 64'(bus.frame_count_out), 64'd1);

    repeat (20) @(negedge clk);
    force dut.frame_cnt_q = 16'hffff;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("wrap_preload", 64'(bus.frame_count_out), 64'hffff);
    q.push_back({48'hdeadbeef0001, 16'h8000});
    build_exp(48'hdeadbeef0001, 16'h8000, 16'hffff);
    rx_frame(1'b0, w);
    check_frame("wrap");
    chk("wrap_seq_hi", 64'(frm[24]), 64'hff);
    chk("wrap_count", 64'(bus.frame_count_out), 64'd0);

    repeat (20) @(negedge clk);
    ev0 = rd_evt;
    q.push_back({48'h0a0b0c0d0e0f, 16'h4321});
    build_exp(48'h0a0b0c0d0e0f, 16'h4321, 16'h0000);
    rx_frame(1'b1, w);
    check_frame("toggle");
    repeat (30) @(negedge clk);
    chk("toggle_reads", 64'(rd_evt - ev0), 64'd1);
    chk("toggle_idle_busy", 64'(bus.busy_out), 64'd0);
    chk("toggle_count", 64'(bus.frame_count_out), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eth_ack_tx.md
ETH_ACK_TX -- requirements
Module: eth_ack_tx

Interface
REQ-001 SHALL have parameter MAC, default 48'h010203040506, meaning the source MAC inserted in every transmitted frame.
REQ-002 SHALL have parameter TYPE, default 16'hffff, meaning the EtherType inserted in every transmitted frame.
REQ-003 SHALL have port clk  input  1  byte clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ack_rd_en_out  output  1  ack FIFO read enable.
REQ-006 SHALL have port ack_rd_d_in  input  64  ack entry: [63:16] destination MAC, [15:0] status word.
REQ-007 SHALL have port ack_rd_empty_in  input  1  ack FIFO empty.
REQ-008 SHALL have port tx_en_out  output  1  transmit byte valid, GMII-style.
REQ-009 SHALL have port txd_out  output  8  transmit byte.
REQ-010 SHALL have port busy_out  output  1  high in every state except IDLE.
REQ-011 SHALL have port frame_count_out  output  16  count of completed frames, wraps 0xffff->0x0000.

Function
REQ-012 ack FIFO handshake: entry is valid in a cycle where ack_rd_en_out was high and ack_rd_empty_in is low; ack_rd_en_out SHALL be driven to !ack_rd_empty_in in IDLE and deasserted in the capture cycle.
REQ-013 States SHALL be IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, IFG; IDLE->PREAMBLE on entry capture; each later state advances when its byte counter reaches its last byte; IFG->IDLE.
REQ-014 tx_en_out SHALL rise the cycle after entry capture and stay high continuously for exactly 72 bytes.
REQ-015 PREAMBLE: 7 bytes 0x55 then 1 byte 0xD5.
REQ-016 HEADER: 14 bytes: destination MAC, MAC, TYPE, each MSB byte first.
REQ-017 PAYLOAD: 46 bytes: status word MSB first, frame_count_out value at capture MSB first, then 42 bytes 0x00.
REQ-018 FCS: 4 bytes of CRC-32 (IEEE, reflected, init 0xFFFFFFFF, final inversion) over HEADER+PAYLOAD bytes, least-significant byte first.
REQ-019 CRC SHALL be reinitialised in PREAMBLE and updated only on HEADER and PAYLOAD bytes.
REQ-020 IFG: tx_en_out low, txd_out 0x00, 12 cycles; no FIFO read during IFG.
REQ-021 frame_count_out SHALL increment in the last FCS cycle.
REQ-022 txd_out SHALL be 0x00 whenever tx_en_out is low.
REQ-023 Minimum entry-to-entry period SHALL be 86 cycles (1 IDLE read + 1 capture + 72 tx + 12 IFG); back-to-back entries need no extra idle.
REQ-024 ack_rd_empty_in changes outside IDLE SHALL be ignored; ack_rd_en_out SHALL stay low outside IDLE.

Reset
REQ-025 On rst all outputs SHALL be 0 and state IDLE, immediately (asynchronous), including mid-frame; a truncated frame is not resumed.
REQ-026 On rst CRC register SHALL be 0xFFFFFFFF and all byte counters 0.

Structure
REQ-027 Shared package SHALL hold state encodings, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY 0xEDB88320, CRC_RESIDUE 0xDEBB20E3, and segment lengths (8/14/46/4/12).
REQ-028 Byte-wide CRC SHALL be sub-module crc32_d8 (clk, rst, init, en, d[7:0], crc[31:0]).

Verification
REQ-029 Single entry {48'h0a0b0c0d0e0f,16'h1234} -> 72 tx bytes: 55x7, D5, 0a 0b 0c 0d 0e 0f 01 02 03 04 05 06 ff ff 12 34 00 00, 42x00, FCS; CRC over bytes 9..72 gives residue 0xDEBB20E3.
REQ-030 Two entries queued -> second frame tx_en_out rises exactly 14 cycles after first falls; sequence bytes 00 00 then 00 01.
REQ-031 FIFO empty for 1000 cycles -> ack_rd_en_out, tx_en_out stay 0, busy_out 0.
REQ-032 rst asserted at byte 30 -> tx_en_out 0 same cycle; after release next entry sent as complete frame with sequence 0x0000.
REQ-033 frame_count_out preloaded to 0xffff via 65535 frames (or forced) -> next frame sequence bytes ff ff, counter then 0x0000.
REQ-034 ack_rd_empty_in toggling during transmit -> no extra reads, frame bytes unchanged.
